// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - decoupled instruction-fetch queue between imem and IF/ID
//
// Issues sequential fetch requests under a credit limit. Returned instructions
// are buffered with their PC+4 in an in-order circular queue and handed to
// decode over a valid/ready handshake. A branch redirect flushes the queue,
// marks in-flight responses for discard and restarts fetching at the target.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   When defined, a live response arriving while the queue is empty is shown
//   on the out_* port in the same cycle. If decode takes it, it never enters
//   the queue.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc     branch redirect from EX (flush + restart)
//   imem_req_valid/addr/ready       fetch request channel
//   imem_resp_valid/instr           in-order fetch responses, never refused
//   out_valid/instr/pc_plus4/ready  instruction stream to IF/ID

module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  input  logic        out_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc4   [DEPTH];

  logic          q_empty;
  logic [CW:0]   credit_used;
  logic [31:0]   resp_pc4;
  logic          resp_live;
  logic          bypass_hit;
  logic          bypass_take;
  logic          req_fire;
  logic          push;
  logic          pop_q;

  assign q_empty     = (occ == '0);
  assign credit_used = {1'b0, occ} + {1'b0, inflight};
  assign resp_pc4    = resp_pc + 32'd4;

  // A response is live only if nothing older still needs discarding and no
  // redirect is killing it in this very cycle.
  assign resp_live = !reset && !redirect_valid && imem_resp_valid && (discard == '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass_hit = resp_live && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Buffered entries plus outstanding fetches may never exceed DEPTH, so every
  // response is guaranteed a free slot.
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < CREDIT_MAX);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid    = !reset && !redirect_valid && (!q_empty || bypass_hit);
  assign out_instr    = bypass_hit ? imem_resp_instr :
                        (q_empty ? 32'h0 : q_instr[rd_ptr]);
  assign out_pc_plus4 = bypass_hit ? resp_pc4 :
                        (q_empty ? 32'h0 : q_pc4[rd_ptr]);

  assign bypass_take = bypass_hit && out_ready;
  assign push        = resp_live && !bypass_take;
  assign pop_q       = out_valid && out_ready && !q_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      occ      <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding belongs to the old path; a response
      // landing right now is already accounted for by dropping it here.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(imem_resp_valid);
      discard  <= inflight - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_live) begin
        resp_pc <= resp_pc4;
      end
      if (imem_resp_valid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
      occ      <= occ + CW'(push) - CW'(pop_q);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_q) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage is not reset; the outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_resp_instr;
      q_pc4[wr_ptr]   <= resp_pc4;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue

module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        out_ready;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc_plus4    (out_pc_plus4),
    .out_ready       (out_ready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory side: pending accepted fetches, oldest first.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          dead;
  } pend_t;
  pend_t pq[$];

  // Reference model: program-order stream of the current path.
  int          live;      // accepted on current path, not yet consumed
  int          avail;     // live responses already returned, not consumed
  int          lat_lo;
  int          lat_hi;
  logic [31:0] exp_next;  // address of next instruction decode should see
  logic [31:0] exp_addr;  // address of next fetch request
  logic [31:0] key;

  logic        s_req_valid;
  logic        s_out_valid;
  logic [31:0] s_pc4;
  logic [31:0] s_instr;

  typedef struct {
    bit          ordy;
    bit          exp_req;
    bit          exp_ov;
    logic [31:0] exp_pc4;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_instr = 32'h0;
    out_ready       = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc4", out_pc_plus4, 32'd0);
    reset = 1'b0;
    pq.delete();
    live     = 0;
    avail    = 0;
    exp_next = RESET_PC;
    exp_addr = RESET_PC;
    cyc      = 0;
  endtask

  // One clock cycle. Caller sets redirect/ready inputs beforehand; memory
  // responses come from the pending queue.
  task automatic step();
    bit    rv;
    bit    rl;
    bit    head_dead;
    bit    ov_exp;
    bit    rq_exp;
    bit    byp_used;
    bit    fire;
    int    dead_n;
    pend_t p;
    rv        = 1'b0;
    head_dead = 1'b0;
    imem_resp_instr = 32'h0;
    if (pq.size() > 0) begin
      if (pq[0].due <= cyc) begin
        rv              = 1'b1;
        head_dead       = pq[0].dead;
        imem_resp_instr = instr_of(pq[0].addr);
      end
    end
    imem_resp_valid = rv;
    #3;
    dead_n = 0;
    foreach (pq[i]) if (pq[i].dead) dead_n++;
    rq_exp = !redirect_valid && ((live + dead_n) < int'(DEPTH));
    rl     = rv && !head_dead && !redirect_valid;
    ov_exp = !redirect_valid && ((avail > 0) || (BYP && rl));

    s_req_valid = imem_req_valid;
    s_out_valid = out_valid;
    s_pc4       = out_pc_plus4;
    s_instr     = out_instr;

    chk("req_valid", 32'(imem_req_valid), 32'(rq_exp));
    if (rq_exp && imem_req_valid) chk("req_addr", imem_req_addr, exp_addr);
    chk("out_valid", 32'(out_valid), 32'(ov_exp));
    if (ov_exp && out_valid) begin
      chk("out_pc_plus4", out_pc_plus4, exp_next + 32'd4);
      chk("out_instr", out_instr, instr_of(exp_next));
    end

    fire = imem_req_valid && imem_req_ready && !redirect_valid;
    if (rv) pq.delete(0);
    if (redirect_valid) begin
      foreach (pq[i]) pq[i].dead = 1'b1;
      live     = 0;
      avail    = 0;
      exp_next = redirect_pc;
      exp_addr = redirect_pc;
    end else begin
      byp_used = 1'b0;
      if (ov_exp && out_ready) begin
        exp_next = exp_next + 32'd4;
        live--;
        if (avail > 0) avail--;
        else byp_used = 1'b1;
      end
      if (rl && !byp_used) avail++;
      if (fire) begin
        p.addr = imem_req_addr;
        p.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        p.dead = 1'b0;
        pq.push_back(p);
        live++;
        exp_addr = exp_addr + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic find_first(input string name, input logic [31:0] want_pc4);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (s_out_valid) begin
        found = 1'b1;
        chk(name, s_pc4, want_pc4);
      end
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill and hold: zero-wait memory, decode stalled for ten cycles.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, BYP,  32'd4};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd4};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd4};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd4};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'd4};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd8};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'd12};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'd16};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'd20};

    key = 32'hA5A5_0000;
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_out_valid", i), 32'(s_out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) chk($sformatf("tbl%0d_pc4", i), s_pc4, tbl[i].exp_pc4);
    end
    for (int i = 0; i < 40; i++) step();

    // Three fetches in flight at redirect, none returned yet.
    do_reset();
    lat_lo = 4; lat_hi = 4;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    chk("rdr_out_valid", 32'(s_out_valid), 32'd0);
    chk("rdr_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    find_first("rdr_first_pc4", 32'h104);

    // Streaming, then redirects in two consecutive cycles (first one
    // coincides with a response, a possible pop and imem_req_ready).
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 8; i++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    chk("rdr2a_out_valid", 32'(s_out_valid), 32'd0);
    chk("rdr2a_req_valid", 32'(s_req_valid), 32'd0);
    redirect_pc = 32'h300;
    step();
    chk("rdr2b_out_valid", 32'(s_out_valid), 32'd0);
    chk("rdr2b_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    find_first("rdr2_first_pc4", 32'h304);

    // Response into an empty queue: same-cycle only with bypass.
    do_reset();
    key = RESET_PC ^ 32'h0000_0013;
    lat_lo = 2; lat_hi = 2;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    step();
    imem_req_ready = 1'b0;
    step();
    step();
    chk("byp_same_cycle_valid", 32'(s_out_valid), 32'(BYP));
    step();
    chk("byp_next_valid", 32'(s_out_valid), 32'd1);
    chk("byp_next_instr", s_instr, 32'h0000_0013);
    chk("byp_next_pc4", s_pc4, RESET_PC + 32'd4);

    // Randomised traffic against the reference model, including wrap.
    key = 32'hA5A5_0000;
    do_reset();
    for (int blk = 0; blk < 16; blk++) begin
      int mode;
      mode   = int'($urandom_range(2, 0));
      lat_lo = 1;
      lat_hi = 1 + int'($urandom_range(4, 0));
      for (int i = 0; i < 250; i++) begin
        redirect_valid = ($urandom_range(15, 0) == 0);
        redirect_pc    = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0
                                                     : ($urandom & 32'hFFFF_FFFC);
        imem_req_ready = ($urandom_range(3, 0) != 0);
        case (mode)
          0:       out_ready = ($urandom_range(1, 0) == 0);
          1:       out_ready = ($urandom_range(9, 0) != 0);
          default: out_ready = ($urandom_range(9, 0) == 0);
        endcase
        step();
      end
    end
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
